dma_req_ctrl_mc: RTL and testbench
==================================

// Module: dma_req_ctrl_mc
// PURPOSE
//  Multi-channel DMA request controller; parametrised successor of the single-channel go/dma_req/data_transfer block.
//  Latches per-channel start requests (go) with a burst length.
//  Arbitrates round-robin among pending channels, handshakes with the bus (dma_req/dma_ack), then drives
//  data_transfer for the programmed number of beats. Adds ack timeout, per-channel abort and done/err reporting.
//  Sits between channel register blocks and the system bus master.
// PARAMETERS
//  NCH      4   number of DMA channels (>=2)
//  LEN_W    8   width of per-channel burst length (beats)
//  MAX_WAIT 16  cycles in REQ without dma_ack before timeout (>=2)
// PORTS
//  clk            in   1             clock, all logic on posedge
//  reset          in   1             synchronous, active-high reset
//  go             in   NCH           per-channel start pulse
//  len            in   NCH*LEN_W     burst length of ch i at [i*LEN_W +: LEN_W], sampled with go[i]
//  abort          in   NCH           per-channel cancel
//  dma_ack        in   1             bus grant, sampled only in REQ
//  beat_ready     in   1             bus accepts the current beat
//  dma_req        out  1             bus request (state==REQ)
//  dma_ch         out  $clog2(NCH)   channel being served, valid while dma_req|data_transfer
//  data_transfer  out  1             beat in progress (state==XFER)
//  busy           out  NCH           channel pending or active
//  done           out  NCH           1-cycle pulse: burst completed
//  err            out  NCH           1-cycle pulse: ack timeout
// BEHAVIOUR
//  Reset:
//   - all outputs 0, state IDLE, pending=0, rr pointer=0.
//   - reset mid-burst drops everything, no done/err.
//  Latching:
//   - go[i] at edge k with len_i!=0 and !busy[i]: pending[i]=1, len latched, busy[i]=1 after k.
//   - go while busy is ignored. go with len=0 is ignored.
//   - go & abort same channel same edge: abort wins, nothing latched.
//  FSM (registered outputs):
//   - IDLE: if any pending, select the first pending channel searching from ptr upward (mod NCH);
//     set dma_ch; ->REQ. dma_req rises one edge after busy.
//   - REQ: wait counter cleared on entry, +1 per cycle.
//     - dma_ack=1: load beat counter with len, ->XFER.
//     - Otherwise, at MAX_WAIT cycles in REQ: err[ch] pulse, clear pending[ch], ->IDLE.
//     - dma_ack on the timeout edge: ack wins.
//   - XFER: a beat counts when data_transfer&beat_ready; counter -1.
//     - On the last beat edge: done[ch] pulse, clear pending[ch], ptr=ch+1 mod NCH, ->IDLE.
//  Abort:
//   - abort[active ch] in REQ/XFER: ->IDLE next edge, pending cleared, no done/err, ptr=ch+1.
//   - Abort of a non-active pending channel clears its pending bit only.
//   - abort on an idle channel: no effect.
//   - abort on the last-beat edge: abort wins (no done).
//  Timing:
//   - At least 1 IDLE cycle between bursts.
//   - dma_ch stable from REQ entry to XFER exit.
//   - done/err are never both high, and never high for 2 consecutive cycles on the same channel.
//   - Beat counter width LEN_W; len max 2**LEN_W-1; no wrap.
// TESTING
//  1 Single burst: go[0], len=3, ack after 2 cycles, beat_ready=1 -> dma_req 2 cycles, data_transfer
//    3 cycles, done[0] 1 pulse, busy[0] falls with done.
//  2 Round-robin: go[0..3] same cycle, len=1, immediate ack -> service order ch0,1,2,3.
//    Then go[0],go[2] -> service order ch2? No: ptr=0 -> ch0 then ch2.
//  3 Timeout: go[1], dma_ack never asserted -> err[1] after 16 REQ cycles, busy[1]=0, no data_transfer.
//    Also ack exactly on the 16th cycle -> XFER, no err.
//  4 Stall/abort: len=4, beat_ready toggled 1010... -> 8 XFER cycles, then done.
//    Same again with abort[ch] after beat 2 -> IDLE, no done.
//  5 Go edge cases: go with len=0 -> ignored; go while busy -> ignored.
//    go+abort same edge -> not latched.
//  6 Reset mid-XFER -> next cycle all outputs 0; a new go is served normally from ch search ptr 0.

Source files
------------

// File: rtl/dma_req_ctrl_mc.sv
// dma_req_ctrl_mc: multi-channel DMA request controller with round-robin arbitration, ack timeout and abort
//   i_clk, i_reset         clock and synchronous active-high reset
//   i_go, i_len            per-channel start pulse and burst length (ch i at [i*LEN_W +: LEN_W])
//   i_abort                per-channel cancel
//   i_dma_ack              bus grant, only looked at while requesting
//   i_beat_ready           bus accepts the current beat
//   o_dma_req, o_dma_ch    bus request and channel being served
//   o_data_transfer        beat in progress
//   o_busy                 channel pending or active
//   o_done, o_err          one-cycle completion / timeout pulses
module dma_req_ctrl_mc #(
    parameter int NCH      = 4,
    parameter int LEN_W    = 8,
    parameter int MAX_WAIT = 16
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [NCH-1:0]           i_go,
    input  logic [NCH*LEN_W-1:0]     i_len,
    input  logic [NCH-1:0]           i_abort,
    input  logic                     i_dma_ack,
    input  logic                     i_beat_ready,
    output logic                     o_dma_req,
    output logic [$clog2(NCH)-1:0]   o_dma_ch,
    output logic                     o_data_transfer,
    output logic [NCH-1:0]           o_busy,
    output logic [NCH-1:0]           o_done,
    output logic [NCH-1:0]           o_err
);
    localparam int CH_W   = $clog2(NCH);
    localparam int WAIT_W = $clog2(MAX_WAIT);

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t            r_state;
    logic [NCH-1:0]    r_pending;
    logic [LEN_W-1:0]  r_len [NCH];
    logic [LEN_W-1:0]  r_beats;
    logic [WAIT_W-1:0] r_wait;
    logic [CH_W-1:0]   r_ptr;
    logic [CH_W-1:0]   r_ch;
    logic [NCH-1:0]    w_set;
    logic [NCH-1:0]    w_cand;
    logic [NCH-1:0]    w_act;
    logic [NCH-1:0]    w_clr;
    logic [CH_W-1:0]   w_sel;
    logic [CH_W-1:0]   w_ptr_nxt;
    logic              w_abort_act;
    logic              w_timeout;
    logic              w_last;
    logic              w_fin;

    assign o_busy    = r_pending;
    assign o_dma_ch  = r_ch;
    assign w_act     = NCH'(1) << r_ch;
    assign w_cand    = r_pending & ~i_abort;
    assign w_ptr_nxt = (r_ch == CH_W'(NCH-1)) ? '0 : r_ch + 1'b1;

    // Abort of the served channel takes priority over ack, timeout and the last beat.
    assign w_abort_act = (r_state != IDLE) && |(i_abort & w_act);
    assign w_timeout   = (r_state == REQ) && !i_dma_ack && (r_wait == WAIT_W'(MAX_WAIT-1));
    assign w_last      = (r_state == XFER) && i_beat_ready && (r_beats == LEN_W'(1));
    assign w_fin       = !w_abort_act && (w_timeout || w_last);
    assign w_clr       = i_abort | (w_fin ? w_act : '0);

    // A go is only taken for an idle channel with a non-zero length and no abort on the same edge.
    always_comb begin
        w_set = '0;
        for (int i = 0; i < NCH; i++)
            w_set[i] = i_go[i] && |i_len[i*LEN_W +: LEN_W] && !r_pending[i] && !i_abort[i];
    end

    // Descending scan so the candidate closest above the pointer is the one kept.
    always_comb begin
        w_sel = '0;
        for (int k = NCH-1; k >= 0; k--)
            if (w_cand[CH_W'((int'(r_ptr) + k) % NCH)])
                w_sel = CH_W'((int'(r_ptr) + k) % NCH);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state         <= IDLE;
            r_pending       <= '0;
            r_beats         <= '0;
            r_wait          <= '0;
            r_ptr           <= '0;
            r_ch            <= '0;
            o_dma_req       <= 1'b0;
            o_data_transfer <= 1'b0;
            o_done          <= '0;
            o_err           <= '0;
            for (int i = 0; i < NCH; i++)
                r_len[i] <= '0;
        end else begin
            o_done    <= '0;
            o_err     <= '0;
            r_pending <= (r_pending & ~w_clr) | w_set;
            for (int i = 0; i < NCH; i++)
                if (w_set[i])
                    r_len[i] <= i_len[i*LEN_W +: LEN_W];
            case (r_state)
                IDLE: begin
                    if (|w_cand) begin
                        r_state   <= REQ;
                        r_ch      <= w_sel;
                        r_wait    <= '0;
                        o_dma_req <= 1'b1;
                    end
                end
                REQ: begin
                    if (w_abort_act) begin
                        r_state   <= IDLE;
                        r_ptr     <= w_ptr_nxt;
                        o_dma_req <= 1'b0;
                    end else if (i_dma_ack) begin
                        r_state         <= XFER;
                        r_beats         <= r_len[r_ch];
                        o_dma_req       <= 1'b0;
                        o_data_transfer <= 1'b1;
                    end else if (w_timeout) begin
                        r_state   <= IDLE;
                        o_dma_req <= 1'b0;
                        o_err     <= w_act;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                XFER: begin
                    if (w_abort_act) begin
                        r_state         <= IDLE;
                        r_ptr           <= w_ptr_nxt;
                        o_data_transfer <= 1'b0;
                    end else if (w_last) begin
                        r_state         <= IDLE;
                        r_ptr           <= w_ptr_nxt;
                        o_data_transfer <= 1'b0;
                        o_done          <= w_act;
                    end else if (i_beat_ready) begin
                        r_beats <= r_beats - 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dma_req_ctrl_mc.sv
// tb_dma_req_ctrl_mc: directed bench for dma_req_ctrl_mc with an event scoreboard
module tb_dma_req_ctrl_mc;
    localparam int NCH   = 4;
    localparam int LEN_W = 8;

    typedef struct packed {
        logic [NCH-1:0] done;
        logic [NCH-1:0] err;
        logic [7:0]     req;
        logic [7:0]     xfer;
    } ev_t;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic [NCH-1:0]       go = '0;
    logic [NCH*LEN_W-1:0] len = '0;
    logic [NCH-1:0]       abort = '0;
    logic                 ack = 1'b0;
    logic                 br = 1'b1;
    logic                 o_dma_req;
    logic [1:0]           o_dma_ch;
    logic                 o_data_transfer;
    logic [NCH-1:0]       o_busy;
    logic [NCH-1:0]       o_done;
    logic [NCH-1:0]       o_err;

    ev_t  q[$];
    int   total = 0;
    int   bad = 0;
    int   req_cyc = 0;
    int   xfer_cyc = 0;
    int   ack_at = 1;
    logic br_alt = 1'b0;

    dma_req_ctrl_mc #(.NCH(NCH), .LEN_W(LEN_W), .MAX_WAIT(16)) dut (
        .i_clk(clk), .i_reset(reset), .i_go(go), .i_len(len), .i_abort(abort),
        .i_dma_ack(ack), .i_beat_ready(br), .o_dma_req(o_dma_req), .o_dma_ch(o_dma_ch),
        .o_data_transfer(o_data_transfer), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: sample after the edge, score any done/err pulse, then drive the bus model.
    task automatic tick();
        ev_t ev;
        @(posedge clk);
        #1;
        if (o_dma_req) req_cyc++;
        if (o_data_transfer) xfer_cyc++;
        if (|(o_done | o_err)) begin
            ev = {o_done, o_err, 8'(req_cyc), 8'(xfer_cyc)};
            chk("busy_at_pulse", 64'(o_busy & (o_done | o_err)), 0);
            if (q.size() == 0) chk("unexpected_pulse", {o_done, o_err}, 0);
            else chk("event", ev, q.pop_front());
            req_cyc  = 0;
            xfer_cyc = 0;
        end
        ack = (ack_at != 0) && o_dma_req && (req_cyc >= ack_at);
        br  = !br_alt || (o_data_transfer && (xfer_cyc % 2 == 0));
    endtask

    task automatic go_len(logic [NCH-1:0] m, logic [LEN_W-1:0] l);
        for (int i = 0; i < NCH; i++)
            if (m[i]) len[i*LEN_W +: LEN_W] = l;
        go = m;
        tick();
        go = '0;
    endtask

    task automatic drain(int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk("drain", 64'(q.size()), 0);
        q.delete();
        repeat (4) tick();
    endtask

    task automatic wait_xfer(int c, int budget);
        int n = 0;
        while (xfer_cyc < c && n < budget) begin
            tick();
            n++;
        end
        chk("wait_xfer", 64'(xfer_cyc), 64'(c));
    endtask

    initial begin
        repeat (3) tick();
        chk("reset_outs", {o_dma_req, o_dma_ch, o_data_transfer, o_busy, o_done, o_err}, 0);
        reset = 1'b0;
        tick();

        // round-robin from pointer 0, then ch0 before ch2
        ack_at = 1;
        q.push_back({4'b0001, 4'b0, 8'd1, 8'd1});
        q.push_back({4'b0010, 4'b0, 8'd1, 8'd1});
        q.push_back({4'b0100, 4'b0, 8'd1, 8'd1});
        q.push_back({4'b1000, 4'b0, 8'd1, 8'd1});
        go_len(4'b1111, 8'd1);
        drain(40);
        q.push_back({4'b0001, 4'b0, 8'd1, 8'd1});
        q.push_back({4'b0100, 4'b0, 8'd1, 8'd1});
        go_len(4'b0101, 8'd1);
        drain(30);

        // single burst, ack after two request cycles
        ack_at = 2;
        q.push_back({4'b0001, 4'b0, 8'd2, 8'd3});
        go_len(4'b0001, 8'd3);
        chk("t1_busy", 64'(o_busy), 64'(4'b0001));
        chk("t1_req_lag", 64'(o_dma_req), 0);
        tick();
        chk("t1_req_up", 64'(o_dma_req), 1);
        drain(20);

        // ack timeout, then ack on the very last wait cycle
        ack_at = 0;
        q.push_back({4'b0000, 4'b0010, 8'd16, 8'd0});
        go_len(4'b0010, 8'd2);
        drain(40);
        chk("t3_busy", 64'(o_busy), 0);
        ack_at = 16;
        q.push_back({4'b0010, 4'b0000, 8'd16, 8'd2});
        go_len(4'b0010, 8'd2);
        drain(40);

        // stalled beats, then abort mid-burst and abort on the last-beat edge
        ack_at = 1;
        br_alt = 1'b1;
        q.push_back({4'b0001, 4'b0, 8'd1, 8'd8});
        go_len(4'b0001, 8'd4);
        drain(40);
        go_len(4'b0001, 8'd4);
        wait_xfer(5, 40);
        abort = 4'b0001;
        tick();
        abort = '0;
        chk("t4_abort", {o_data_transfer, o_busy, o_done, o_err}, 0);
        req_cyc  = 0;
        xfer_cyc = 0;
        br_alt = 1'b0;
        go_len(4'b0010, 8'd1);
        wait_xfer(1, 20);
        abort = 4'b0010;
        tick();
        abort = '0;
        chk("t4_abort_last", {o_data_transfer, o_busy, o_done, o_err}, 0);
        req_cyc  = 0;
        xfer_cyc = 0;

        // abort of a waiting channel leaves the served one alone
        q.push_back({4'b0001, 4'b0, 8'd1, 8'd2});
        go_len(4'b0011, 8'd2);
        tick();
        abort = 4'b0010;
        tick();
        abort = '0;
        chk("t4_abort_waiting", 64'(o_busy), 64'(4'b0001));
        drain(20);

        // go edge cases
        go_len(4'b0100, 8'd0);
        chk("t5_len0", 64'(o_busy), 0);
        q.push_back({4'b0010, 4'b0, 8'd1, 8'd2});
        go_len(4'b0010, 8'd2);
        go_len(4'b0010, 8'd7);
        drain(20);
        len[3*LEN_W +: LEN_W] = 8'd3;
        go    = 4'b1000;
        abort = 4'b1000;
        tick();
        go    = '0;
        abort = '0;
        chk("t5_go_abort", 64'(o_busy), 0);
        tick();
        chk("t5_go_abort_req", 64'(o_dma_req), 0);

        // reset in the middle of a burst
        go_len(4'b0100, 8'd10);
        wait_xfer(3, 30);
        reset = 1'b1;
        tick();
        chk("t6_reset_outs", {o_dma_req, o_dma_ch, o_data_transfer, o_busy, o_done, o_err}, 0);
        reset = 1'b0;
        req_cyc  = 0;
        xfer_cyc = 0;
        q.push_back({4'b0010, 4'b0, 8'd1, 8'd1});
        q.push_back({4'b1000, 4'b0, 8'd1, 8'd1});
        go_len(4'b1010, 8'd1);
        drain(30);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
